// File: rtl/rob_commit_buffer.sv
// In-order reorder buffer: allocates at tail, marks ready from the CDB, retires one entry per cycle from head.
// Define ROB_BRANCH_PRED_EN to track branch predictions and self-flush younger entries on a mispredicted retire.
module rob_commit_buffer #(
  parameter int ROB_DEPTH     = 32,
  parameter int PHY_REG_COUNT = 128,
  parameter int ARCH_WIDTH    = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             disp_valid,
  input  logic [ARCH_WIDTH-1:0]            disp_rd_s,
  input  logic [$clog2(PHY_REG_COUNT)-1:0] disp_pd_s,
`ifdef ROB_BRANCH_PRED_EN
  input  logic                             disp_br_valid,
  input  logic                             disp_br_pred_taken,
  input  logic                             cdb_br_taken,
  output logic                             commit_mispredict,
`endif
  output logic                             disp_ready,
  output logic [$clog2(ROB_DEPTH)-1:0]     disp_rob_idx,
  input  logic                             cdb_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0]     cdb_rob_idx,
  input  logic                             flush,
  output logic                             commit_valid,
  output logic [ARCH_WIDTH-1:0]            commit_rd_s,
  output logic [$clog2(PHY_REG_COUNT)-1:0] commit_pd_s,
  output logic [$clog2(ROB_DEPTH)-1:0]     commit_rob_idx,
  output logic [63:0]                      commit_order,
  output logic                             rob_empty
);

  localparam int IW = $clog2(ROB_DEPTH);
  localparam int PW = $clog2(PHY_REG_COUNT);
  localparam logic [IW:0] FULL_COUNT = (IW+1)'(ROB_DEPTH);

  logic                  valid_reg [ROB_DEPTH];
  logic                  ready_reg [ROB_DEPTH];
  logic [ARCH_WIDTH-1:0] arch_mem  [ROB_DEPTH];
  logic [PW-1:0]         phys_mem  [ROB_DEPTH];
  logic [IW-1:0]         head_reg;
  logic [IW-1:0]         tail_reg;
  logic [IW:0]           count_reg;
  logic [63:0]           order_reg;

  logic dispatch;
  logic retire;
  logic kill;

  assign disp_ready = (count_reg != FULL_COUNT);
  assign dispatch   = disp_valid && disp_ready;
  assign retire     = valid_reg[head_reg] && ready_reg[head_reg] && !flush;

`ifdef ROB_BRANCH_PRED_EN
  logic br_valid_mem [ROB_DEPTH];
  logic br_pred_mem  [ROB_DEPTH];
  logic br_taken_reg [ROB_DEPTH];
  logic mispredict;

  assign mispredict = retire && br_valid_mem[head_reg] &&
                      (br_pred_mem[head_reg] != br_taken_reg[head_reg]);
  assign commit_mispredict = mispredict;
  // A mispredicted head retires normally; everything younger is discarded at the same edge.
  assign kill = flush || mispredict;
`else
  assign kill = flush;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      localparam logic [IW-1:0] IDX = IW'(gi);

      always_ff @(posedge clk) begin
        if (rst || kill) begin
          valid_reg[gi] <= 1'b0;
          ready_reg[gi] <= 1'b0;
        end else if (dispatch && (tail_reg == IDX)) begin
          valid_reg[gi] <= 1'b1;
          ready_reg[gi] <= 1'b0;
        end else begin
          if (retire && (head_reg == IDX)) begin
            valid_reg[gi] <= 1'b0;
          end
          // Completions for entries that are not in flight are dropped.
          if (cdb_valid && (cdb_rob_idx == IDX) && valid_reg[gi]) begin
            ready_reg[gi] <= 1'b1;
`ifdef ROB_BRANCH_PRED_EN
            br_taken_reg[gi] <= cdb_br_taken;
`endif
          end
        end
      end
    end
  endgenerate

  // Payload needs no reset: it is only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (dispatch) begin
      arch_mem[tail_reg] <= disp_rd_s;
      phys_mem[tail_reg] <= disp_pd_s;
`ifdef ROB_BRANCH_PRED_EN
      br_valid_mem[tail_reg] <= disp_br_valid;
      br_pred_mem[tail_reg]  <= disp_br_pred_taken;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      order_reg <= '0;
    end else begin
      if (retire) begin
        order_reg <= order_reg + 64'd1;
      end
      if (kill) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (retire) begin
          head_reg <= head_reg + IW'(1);
        end
        if (dispatch) begin
          tail_reg <= tail_reg + IW'(1);
        end
        count_reg <= count_reg + (IW+1)'(dispatch) - (IW+1)'(retire);
      end
    end
  end

  assign disp_rob_idx   = tail_reg;
  assign commit_valid   = retire;
  assign commit_rd_s    = arch_mem[head_reg];
  assign commit_pd_s    = phys_mem[head_reg];
  assign commit_rob_idx = head_reg;
  assign commit_order   = order_reg;
  assign rob_empty      = (count_reg == '0);

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Directed bench for rob_commit_buffer with a queue-based program-order model checked every cycle.
// Define ROB_BRANCH_PRED_EN to also exercise the mispredict self-flush.
module tb_rob_commit_buffer;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        disp_valid;
  logic [4:0]  disp_rd_s;
  logic [6:0]  disp_pd_s;
  logic        disp_ready;
  logic [4:0]  disp_rob_idx;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_idx;
  logic        flush;
  logic        commit_valid;
  logic [4:0]  commit_rd_s;
  logic [6:0]  commit_pd_s;
  logic [4:0]  commit_rob_idx;
  logic [63:0] commit_order;
  logic        rob_empty;
`ifdef ROB_BRANCH_PRED_EN
  logic        disp_br_valid;
  logic        disp_br_pred_taken;
  logic        cdb_br_taken;
  logic        commit_mispredict;
`endif

  rob_commit_buffer #(.ROB_DEPTH(32), .PHY_REG_COUNT(128), .ARCH_WIDTH(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .disp_valid     (disp_valid),
    .disp_rd_s      (disp_rd_s),
    .disp_pd_s      (disp_pd_s),
`ifdef ROB_BRANCH_PRED_EN
    .disp_br_valid      (disp_br_valid),
    .disp_br_pred_taken (disp_br_pred_taken),
    .cdb_br_taken       (cdb_br_taken),
    .commit_mispredict  (commit_mispredict),
`endif
    .disp_ready     (disp_ready),
    .disp_rob_idx   (disp_rob_idx),
    .cdb_valid      (cdb_valid),
    .cdb_rob_idx    (cdb_rob_idx),
    .flush          (flush),
    .commit_valid   (commit_valid),
    .commit_rd_s    (commit_rd_s),
    .commit_pd_s    (commit_pd_s),
    .commit_rob_idx (commit_rob_idx),
    .commit_order   (commit_order),
    .rob_empty      (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: in-flight instructions in program order, oldest first.
  typedef struct {
    int idx;
    int rd;
    int pd;
    bit rdy;
    bit br;
    bit pred;
    bit tk;
  } ent_t;

  ent_t   q[$];
  int     m_tail = 0;
  longint m_order = 0;
  bit     model_live = 0;

  function automatic bit exp_commit();
    return (q.size() > 0) && q[0].rdy && !flush;
  endfunction

  function automatic bit exp_mispredict();
    return exp_commit() && q[0].br && (q[0].pred != q[0].tk);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_tail     = 0;
      m_order    = 0;
      model_live = 1;
    end else if (model_live) begin
      bit full;
      bit cv;
      bit mis;
      ent_t e;
      full = (q.size() == DEPTH);
      cv   = exp_commit();
      mis  = exp_mispredict();
      if (flush) begin
        q.delete();
        m_tail = 0;
      end else begin
        if (cdb_valid) begin
          for (int j = 0; j < q.size(); j++) begin
            if (q[j].idx == int'(cdb_rob_idx)) begin
              q[j].rdy = 1;
`ifdef ROB_BRANCH_PRED_EN
              q[j].tk = cdb_br_taken;
`endif
            end
          end
        end
        if (cv) begin
          void'(q.pop_front());
          m_order++;
        end
        if (mis) begin
          q.delete();
          m_tail = 0;
        end else if (disp_valid && !full) begin
          e.idx = m_tail;
          e.rd  = int'(disp_rd_s);
          e.pd  = int'(disp_pd_s);
          e.rdy = 0;
          e.br  = 0;
          e.pred = 0;
          e.tk  = 0;
`ifdef ROB_BRANCH_PRED_EN
          e.br   = disp_br_valid;
          e.pred = disp_br_pred_taken;
`endif
          q.push_back(e);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("m_disp_ready", disp_ready, (q.size() != DEPTH));
      chk("m_disp_rob_idx", disp_rob_idx, m_tail);
      chk("m_rob_empty", rob_empty, (q.size() == 0));
      chk("m_commit_valid", commit_valid, exp_commit());
      chk("m_commit_order", commit_order, m_order);
`ifdef ROB_BRANCH_PRED_EN
      chk("m_commit_mispredict", commit_mispredict, exp_mispredict());
`endif
      if (exp_commit()) begin
        chk("m_commit_rd", commit_rd_s, q[0].rd);
        chk("m_commit_pd", commit_pd_s, q[0].pd);
        chk("m_commit_idx", commit_rob_idx, q[0].idx);
      end
    end
  end

  task automatic idle_inputs();
    disp_valid  = 0;
    disp_rd_s   = 0;
    disp_pd_s   = 0;
    cdb_valid   = 0;
    cdb_rob_idx = 0;
    flush       = 0;
`ifdef ROB_BRANCH_PRED_EN
    disp_br_valid      = 0;
    disp_br_pred_taken = 0;
    cdb_br_taken       = 0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic disp(input int rd, input int pd);
    disp_valid = 1;
    disp_rd_s  = 5'(rd);
    disp_pd_s  = 7'(pd);
  endtask

  task automatic cdb(input int idx);
    cdb_valid   = 1;
    cdb_rob_idx = 5'(idx);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    settle();
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_disp_idx", disp_rob_idx, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_order", commit_order, 0);
    chk("rst_empty", rob_empty, 1);

    // Three allocations, then out-of-order completion.
    for (int i = 0; i < 3; i++) begin
      disp(i + 1, 40 + i);
      settle();
      chk("alloc3_idx", disp_rob_idx, i);
      step();
    end
    settle();
    chk("alloc3_not_empty", rob_empty, 0);
    chk("alloc3_no_commit", commit_valid, 0);
    cdb(1);
    step();
    settle();
    chk("cdb1_no_commit", commit_valid, 0);
    cdb(0);
    step();
    settle();
    chk("c0_valid", commit_valid, 1);
    chk("c0_rd", commit_rd_s, 1);
    chk("c0_pd", commit_pd_s, 40);
    chk("c0_order", commit_order, 0);
    step();
    settle();
    chk("c1_valid", commit_valid, 1);
    chk("c1_rd", commit_rd_s, 2);
    chk("c1_pd", commit_pd_s, 41);
    chk("c1_order", commit_order, 1);
    step();
    settle();
    chk("c2_pending", commit_valid, 0);

    // Fill to capacity, check the stall and the wrap.
    flush = 1;
    step();
    for (int i = 0; i < 32; i++) begin
      disp(i, 64 + i);
      settle();
      chk("fill_idx", disp_rob_idx, i);
      step();
    end
    settle();
    chk("full_ready", disp_ready, 0);
    disp(31, 1);
    step();
    settle();
    chk("full_ignored_idx", disp_rob_idx, 0);
    chk("full_ignored_ready", disp_ready, 0);
    cdb(0);
    step();
    settle();
    chk("full_commit_valid", commit_valid, 1);
    chk("full_commit_pd", commit_pd_s, 64);
    chk("full_commit_order", commit_order, 2);
    chk("full_commit_stall", disp_ready, 0);
    step();
    settle();
    chk("after_commit_ready", disp_ready, 1);
    chk("wrap_idx", disp_rob_idx, 0);
    disp(7, 99);
    step();
    settle();
    chk("refull_ready", disp_ready, 0);

    // Reset while full; a stale completion afterwards must do nothing.
    rst = 1;
    step();
    rst = 0;
    settle();
    chk("rst2_ready", disp_ready, 1);
    chk("rst2_idx", disp_rob_idx, 0);
    chk("rst2_commit", commit_valid, 0);
    chk("rst2_order", commit_order, 0);
    chk("rst2_empty", rob_empty, 1);
    cdb(3);
    step();
    settle();
    chk("stale_cdb_commit", commit_valid, 0);
    chk("stale_cdb_empty", rob_empty, 1);
    step();
    settle();
    chk("stale_cdb_commit2", commit_valid, 0);

    // Flush with five in flight and a ready head; order survives.
    for (int i = 0; i < 6; i++) begin
      disp(10 + i, 60 + i);
      step();
    end
    cdb(0);
    step();
    cdb(1);
    settle();
    chk("pre_flush_commit", commit_valid, 1);
    chk("pre_flush_pd", commit_pd_s, 60);
    chk("pre_flush_order", commit_order, 0);
    step();
    settle();
    chk("head_ready", commit_valid, 1);
    chk("head_ready_rd", commit_rd_s, 11);
    flush = 1;
    #1;
    chk("flush_kills_commit", commit_valid, 0);
    step();
    settle();
    chk("post_flush_empty", rob_empty, 1);
    chk("post_flush_idx", disp_rob_idx, 0);
    chk("post_flush_order", commit_order, 1);
    disp(9, 33);
    step();
    cdb(0);
    step();
    settle();
    chk("post_flush_commit", commit_valid, 1);
    chk("post_flush_commit_order", commit_order, 1);
    chk("post_flush_commit_pd", commit_pd_s, 33);
    step();

`ifdef ROB_BRANCH_PRED_EN
    // Correctly predicted branch retires quietly.
    disp(4, 50);
    disp_br_valid      = 1;
    disp_br_pred_taken = 0;
    step();
    cdb(1);
    cdb_br_taken = 0;
    step();
    settle();
    chk("br_ok_commit", commit_valid, 1);
    chk("br_ok_mispredict", commit_mispredict, 0);
    step();
    // Mispredicted branch with two younger entries.
    disp(1, 20);
    disp_br_valid      = 1;
    disp_br_pred_taken = 1;
    settle();
    chk("br_idx", disp_rob_idx, 2);
    step();
    disp(2, 21);
    step();
    disp(3, 22);
    step();
    cdb(2);
    cdb_br_taken = 0;
    step();
    settle();
    chk("br_mis_commit", commit_valid, 1);
    chk("br_mis_flag", commit_mispredict, 1);
    chk("br_mis_order", commit_order, 3);
    step();
    settle();
    chk("br_mis_empty", rob_empty, 1);
    chk("br_mis_idx", disp_rob_idx, 0);
    chk("br_mis_order_next", commit_order, 4);
`endif

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit_buffer.md
Name: rob_commit_buffer

Overview:
- Reorder buffer between rename/dispatch and architectural commit in the OoO RV32I core.
- Allocates one in-order entry per dispatched instruction and returns its ROB index for the reservation station's rob_idx field.
- Marks entries ready from the CDB; retires at most one instruction per cycle from the head, in program order.
- Drives RRAT/free-list updates and the RVFI order counter.

Parameters:
- ROB_DEPTH, 32, number of entries; must be a power of 2, at least 4.
- PHY_REG_COUNT, 128, physical register count; pd width = $clog2(PHY_REG_COUNT).
- ARCH_WIDTH, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- disp_valid  in  1  dispatch requests an entry this cycle.
- disp_rd_s  in  ARCH_WIDTH  architectural destination.
- disp_pd_s  in  $clog2(PHY_REG_COUNT)  physical destination.
- disp_ready  out  1  ROB can accept; high when not full.
- disp_rob_idx  out  $clog2(ROB_DEPTH)  index allocated when disp_valid && disp_ready (equals tail).
- cdb_valid  in  1  a functional unit completed.
- cdb_rob_idx  in  $clog2(ROB_DEPTH)  entry to mark ready.
- flush  in  1  discard all entries.
- commit_valid  out  1  head retires this cycle.
- commit_rd_s  out  ARCH_WIDTH  retired architectural register.
- commit_pd_s  out  $clog2(PHY_REG_COUNT)  retired physical register.
- commit_rob_idx  out  $clog2(ROB_DEPTH)  retired index (equals head).
- commit_order  out  64  RVFI order of the retiring instruction.
- rob_empty  out  1  count == 0.

Behaviour:
- Per-entry state: valid, ready, arch, phys. Pointers head and tail are $clog2(ROB_DEPTH) bits and wrap naturally. count is $clog2(ROB_DEPTH)+1 bits.
- Reset (synchronous, rst high at a clk edge):
  - all valid and ready bits cleared; head = tail = count = 0; order = 0.
  - outputs: disp_ready=1, disp_rob_idx=0, commit_valid=0, commit_order=0, rob_empty=1.
  - Reset mid-operation discards all in-flight entries with no commit.
- disp_ready = (count != ROB_DEPTH). It does not account for a same-cycle commit, so a full ROB stalls dispatch for one cycle.
- Dispatch (disp_valid && disp_ready): write entry[tail] = {valid=1, ready=0, arch, phys}; tail++ at the edge. disp_valid while !disp_ready is ignored; no state changes.
- CDB: if cdb_valid && entry[cdb_rob_idx].valid, set ready=1 at the edge. A CDB write to an invalid entry is ignored.
- Commit is combinational from registered state:
  - commit_valid = entry[head].valid && entry[head].ready && !flush.
  - When commit_valid is high: clear entry[head].valid at the edge; head++; order++.
  - commit_order = current order value, before the increment.
- Latency: dispatch at edge N, CDB at cycle N+1 earliest, commit_valid high in cycle N+2.
- Simultaneous dispatch and commit: count unchanged; both pointers advance.
- CDB hitting the head in the same cycle: ready is registered, so commit happens the next cycle.
- Full (count == ROB_DEPTH): head == tail. Empty (count == 0): head == tail and rob_empty = 1.
- Flush has priority over dispatch, CDB and commit in the same cycle:
  - clear all valid bits; head = tail = count = 0.
  - order is kept; commit_valid is forced to 0 in the flush cycle.
- No state machine beyond the pointer/count state.

Optional Feature:
- Macro: ROB_BRANCH_PRED_EN.
- When defined, add the following ports:
  - disp_br_valid in 1, disp_br_pred_taken in 1: stored per entry.
  - cdb_br_taken in 1: actual outcome, stored with ready.
  - commit_mispredict out 1: commit_valid && br_valid && (pred != actual).
- On a commit_mispredict cycle the entry retires normally. At the same edge the ROB performs the flush action on all younger entries (head = tail = count = 0) without the external flush input.
- commit_mispredict resets to 0.
- When undefined: none of these ports or fields exist, and there is no internal flush.

Test Plan:
- Reset, then dispatch 3 entries (rd=1/2/3, pd=40/41/42) -> disp_rob_idx 0,1,2; rob_empty=0; no commit.
- CDB idx 1, then idx 0 -> commit rd=1/pd=40 with order 0, then rd=2/pd=41 with order 1 on consecutive cycles; idx 2 is not committed.
- Dispatch 32 entries without CDB -> disp_ready=0 after the 32nd; 33rd disp_valid ignored; CDB idx 0 -> commit, then disp_ready=1 one cycle later; next allocation gets idx 0 (wrap).
- 5 entries in flight with head ready, assert flush -> commit_valid=0 that cycle; next cycle rob_empty=1, disp_rob_idx=0; commit_order continues from its prior value.
- Assert rst while full -> all outputs at reset values next cycle; a stale CDB to idx 3 sets nothing and produces no commit.
- With ROB_BRANCH_PRED_EN: dispatch branch (pred=1) plus 2 younger entries; CDB with taken=0 -> commit_mispredict=1 on retire; next cycle rob_empty=1.
